// File: rtl/rr_sched_pkg.sv
// rr_sched_pkg: shared types and constants for the round-robin bus scheduler.
//   rr_sched_state_e : scheduler FSM states
//   enc_width()      : width of the encoded-owner bus for a given master count
//   GRANT_IDLE       : all-ones pattern driven on the encoded owner when idle
package rr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    TURN
  } rr_sched_state_e;

  function automatic int unsigned enc_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  localparam logic [31:0] GRANT_IDLE = '1;

endpackage

// File: rtl/rr_bus_scheduler_pick.sv
// rr_pick: combinational masked round-robin priority picker.
//   req    : request vector
//   last   : index of the previous owner; search starts just above it
//   onehot : one-hot winner (zero when no request)
//   enc    : encoded winner (all-ones when no request)
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter int unsigned NumMasters = 4
) (
  input  logic [NumMasters-1:0]      req,
  input  logic [$clog2(NumMasters)-1:0] last,
  output logic [NumMasters-1:0]      onehot,
  output logic [$clog2(NumMasters):0] enc
);

  localparam int unsigned DW   = 2 * NumMasters;
  localparam int unsigned EncW = enc_width(NumMasters);

  logic [DW-1:0] dreq;
  logic [DW-1:0] base;
  logic [DW-1:0] win;

  // The request vector is duplicated so the search from last+1 naturally
  // wraps: x & ~(x - base) isolates the lowest set bit at or above base.
  always_comb begin
    dreq   = {req, req};
    base   = DW'(1) << (int'(last) + 1);
    win    = dreq & ~(dreq - base);
    onehot = win[NumMasters-1:0] | win[DW-1:NumMasters];
    enc    = GRANT_IDLE[EncW-1:0];
    for (int unsigned i = 0; i < NumMasters; i++) begin
      if (onehot[i]) enc = EncW'(i);
    end
  end

endmodule

// File: rtl/rr_bus_scheduler.sv
// rr_bus_scheduler: round-robin owner selection for one shared bus port.
//   clk, rst   : clock, asynchronous active-high reset
//   ce         : clock enable; all state holds while low
//   req, lock  : per-master level request and keep-bus-after-ack
//   ack_i      : slave transaction-complete strobe
//   grant      : registered one-hot owner (zero when idle)
//   grant_enc  : registered encoded owner (all-ones when idle)
//   cyc_o      : bus cycle active (BUSY)
//   timeout_o  : one-cycle pulse when the watchdog reclaims the bus
module rr_bus_scheduler
  import rr_sched_pkg::*;
#(
  parameter int unsigned NumMasters    = 4,
  parameter int unsigned MaxBurst      = 16,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic [NumMasters-1:0]         req,
  input  logic [NumMasters-1:0]         lock,
  input  logic                          ack_i,
  output logic [NumMasters-1:0]         grant,
  output logic [$clog2(NumMasters):0]   grant_enc,
  output logic                          cyc_o,
  output logic                          timeout_o
);

  localparam int unsigned IdxW   = $clog2(NumMasters);
  localparam int unsigned EncW   = enc_width(NumMasters);
  localparam int unsigned BurstW = $clog2(MaxBurst + 1);
  localparam int unsigned TmoW   = $clog2(TimeoutCycles + 1);
  localparam logic [IdxW-1:0] LastRst = IdxW'(NumMasters - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  rr_sched_state_e state, state_n;

  logic [NumMasters-1:0] grant_n;
  logic [NumMasters-1:0] pick_oh;
  logic [EncW-1:0]       grant_enc_n;
  logic [EncW-1:0]       pick_enc;
  logic                  cyc_n;
  logic                  timeout_n;
  logic [BurstW-1:0]     burst_cnt, burst_n;
  logic [TmoW-1:0]       tmo_cnt, tmo_n;
  logic [IdxW-1:0]       last_owner, last_n;
  logic [IdxW-1:0]       owner;
  logic                  others;
  logic                  keep;
  logic                  rel;

  rr_pick #(.NumMasters(NumMasters)) u_pick (
    .req    (req),
    .last   (last_owner),
    .onehot (pick_oh),
    .enc    (pick_enc)
  );

  always_comb begin
    owner  = grant_enc[IdxW-1:0];
    others = |(req & ~grant);
    keep   = lock[owner] && req[owner] &&
             (((32'(burst_cnt) + 32'd1) < MaxBurst) || !others);
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    grant_enc_n = grant_enc;
    cyc_n       = cyc_o;
    timeout_n   = 1'b0;
    burst_n     = burst_cnt;
    tmo_n       = tmo_cnt;
    last_n      = last_owner;
    rel         = 1'b0;
    unique case (state)
      // TURN shares the arbitration path with IDLE so the next owner is
      // granted on the edge that ends the single turnaround cycle.
      IDLE, TURN: begin
        state_n     = IDLE;
        grant_n     = '0;
        grant_enc_n = GRANT_IDLE[EncW-1:0];
        cyc_n       = 1'b0;
        if (|req) begin
          state_n     = BUSY;
          grant_n     = pick_oh;
          grant_enc_n = pick_enc;
          cyc_n       = 1'b1;
          burst_n     = '0;
          tmo_n       = '0;
        end
      end
      BUSY: begin
        if (ack_i) begin
          if (keep) begin
            if (burst_cnt != '1) burst_n = burst_cnt + 1'b1;
            tmo_n = '0;
          end else begin
            rel = 1'b1;
          end
        end else if (!req[owner]) begin
          rel = 1'b1;
        end else if (tmo_cnt == TmoLast) begin
          rel       = 1'b1;
          timeout_n = 1'b1;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
        // The released owner is captured here because grant_enc is
        // already cleared during TURN.
        if (rel) begin
          state_n     = TURN;
          grant_n     = '0;
          grant_enc_n = GRANT_IDLE[EncW-1:0];
          cyc_n       = 1'b0;
          last_n      = owner;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      grant_enc  <= GRANT_IDLE[EncW-1:0];
      cyc_o      <= 1'b0;
      timeout_o  <= 1'b0;
      burst_cnt  <= '0;
      tmo_cnt    <= '0;
      last_owner <= LastRst;
    end else if (ce) begin
      state      <= state_n;
      grant      <= grant_n;
      grant_enc  <= grant_enc_n;
      cyc_o      <= cyc_n;
      timeout_o  <= timeout_n;
      burst_cnt  <= burst_n;
      tmo_cnt    <= tmo_n;
      last_owner <= last_n;
    end
  end

endmodule

// File: tb/tb_rr_bus_scheduler.sv
module tb_rr_bus_scheduler;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [3:0] req;
  logic [3:0] lock;
  logic       ack_i;
  logic [3:0] grant;
  logic [2:0] grant_enc;
  logic       cyc_o;
  logic       timeout_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model: owner index (-1 = nobody), turnaround flag,
  // previous owner, acks consumed this tenure, idle BUSY cycles.
  int m_owner, m_last, m_acks, m_wait;
  bit m_gap, m_tmo;

  always #5 clk = ~clk;

  rr_bus_scheduler #(
    .NumMasters    (N),
    .MaxBurst      (MB),
    .TimeoutCycles (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .req       (req),
    .lock      (lock),
    .ack_i     (ack_i),
    .grant     (grant),
    .grant_enc (grant_enc),
    .cyc_o     (cyc_o),
    .timeout_o (timeout_o)
  );

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_acks = 0; m_wait = 0; m_gap = 0; m_tmo = 0;
  endtask

  task automatic model_grant();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (req[idx]) begin
        m_owner = idx; m_acks = 0; m_wait = 0;
        break;
      end
    end
  endtask

  task automatic model_release(input int g);
    m_last = g; m_owner = -1; m_gap = 1;
  endtask

  task automatic model_step();
    int  g;
    bit  others;
    if (rst) begin model_reset(); return; end
    if (!ce) return;
    m_tmo = 0;
    if (m_gap) begin
      m_gap = 0;
      model_grant();
    end else if (m_owner < 0) begin
      model_grant();
    end else begin
      g = m_owner;
      others = (req & ~(4'(1) << g)) != 0;
      if (ack_i) begin
        if (lock[g] && req[g] && ((m_acks + 1 < MB) || !others)) begin
          m_acks++; m_wait = 0;
        end else model_release(g);
      end else if (!req[g]) begin
        model_release(g);
      end else if (m_wait == TO - 1) begin
        model_release(g); m_tmo = 1;
      end else m_wait++;
    end
  endtask

  function automatic logic [8:0] exp_vec();
    if (m_owner >= 0) return {4'(1) << m_owner, 3'(m_owner), 1'b1, m_tmo};
    return {4'b0000, 3'b111, 1'b0, m_tmo};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b1; req = '0; lock = '0; ack_i = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; req = '0; lock = '0; ack_i = 1'b0;
    model_reset();
    #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant: got %b expected 0000", grant); end
    total++; if (grant_enc !== 3'b111) begin bad++; $display("FAIL rst_enc: got %b expected 111", grant_enc); end
    total++; if (cyc_o !== 1'b0) begin bad++; $display("FAIL rst_cyc: got %b expected 0", cyc_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL rst_tmo: got %b expected 0", timeout_o); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_reset();
    req = 4'b1010;
    step();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL dir_grant1: got %b expected 0010", grant); end
    total++; if (grant_enc !== 3'd1) begin bad++; $display("FAIL dir_enc1: got %0d expected 1", grant_enc); end
    total++; if (cyc_o !== 1'b1) begin bad++; $display("FAIL dir_cyc1: got %b expected 1", cyc_o); end
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    total++; if ({grant, grant_enc, cyc_o} !== {4'b0000, 3'b111, 1'b0}) begin
      bad++; $display("FAIL dir_turn: got %b/%b/%b expected 0000/111/0", grant, grant_enc, cyc_o);
    end
    step();
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL dir_grant2: got %b expected 1000", grant); end
    req = '0;
  endtask

  task automatic test_round_robin();
    int got[$];
    int expq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111; ack_i = 1'b1;
    for (int c = 0; c < 30 && got.size() < 5; c++) begin
      step();
      total++; if ({grant, grant_enc, cyc_o, timeout_o} !== exp_vec()) begin
        bad++; $display("FAIL rr_cycle: got %b expected %b", {grant, grant_enc, cyc_o, timeout_o}, exp_vec());
      end
      if (cyc_o) got.push_back(int'(grant_enc));
    end
    total++; if (got.size() != 5) begin bad++; $display("FAIL rr_count: got %0d grants expected 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      total++; if (got[i] != expq[i]) begin bad++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got[i], expq[i]); end
    end
    req = '0; ack_i = 1'b0;
  endtask

  task automatic test_lock_burst();
    int n;
    do_reset();
    req = 4'b0100; lock = 4'b0100;
    step();
    ack_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL lock_hold[%0d]: got %b expected 0100", c, grant); end
    end
    ack_i = 1'b0;
    do_reset();
    req = 4'b0100; lock = 4'b0100;
    step();
    req = 4'b0101; ack_i = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      n++;
      if (grant !== 4'b0100) break;
    end
    total++; if (n != MB) begin bad++; $display("FAIL burst_len: got %0d acks expected %0d", n, MB); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL burst_gap: got %b expected 0000", grant); end
    ack_i = 1'b0;
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL burst_next: got %b expected 0001", grant); end
    req = '0; lock = '0;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req = 4'b0001;
    step();
    n = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      n++;
      if (timeout_o === 1'b1) break;
    end
    total++; if (n != TO) begin bad++; $display("FAIL tmo_delay: got %0d cycles expected %0d", n, TO); end
    total++; if ({grant, cyc_o} !== 5'b00000) begin bad++; $display("FAIL tmo_release: got %b expected 00000", {grant, cyc_o}); end
    step();
    total++; if ({grant, timeout_o} !== 5'b00010) begin bad++; $display("FAIL tmo_regrant: got %b expected 00010", {grant, timeout_o}); end
    for (int c = 0; c < TO - 1; c++) step();
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL tmo_ackwins: got %b expected 0", timeout_o); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL tmo_ackrel: got %b expected 0000", grant); end
    req = '0;
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b0011;
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL abort_g0: got %b expected 0001", grant); end
    req = 4'b0010;
    step();
    total++; if ({grant, cyc_o, timeout_o} !== 6'b000000) begin bad++; $display("FAIL abort_turn: got %b expected 000000", {grant, cyc_o, timeout_o}); end
    step();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL abort_next: got %b expected 0010", grant); end
    req = '0;
  endtask

  task automatic test_rst_ce();
    do_reset();
    req = 4'b0001;
    step();
    ce = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    total++; if ({grant, grant_enc, cyc_o, timeout_o} !== {4'b0000, 3'b111, 2'b00}) begin
      bad++; $display("FAIL async_rst: got %b expected 000011100", {grant, grant_enc, cyc_o, timeout_o});
    end
    rst = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if ({grant, cyc_o} !== 5'b00000) begin bad++; $display("FAIL ce_hold[%0d]: got %b expected 00000", c, {grant, cyc_o}); end
    end
    ce = 1'b1;
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL ce_resume: got %b expected 0001", grant); end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ce = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 15) == 0) lock = 4'($urandom);
      ack_i = ($urandom_range(0, 5) == 0);
      step();
      total++; if ({grant, grant_enc, cyc_o, timeout_o} !== exp_vec()) begin
        bad++; $display("FAIL rand[%0d]: got %b expected %b", c, {grant, grant_enc, cyc_o, timeout_o}, exp_vec());
      end
    end
    req = '0; lock = '0; ack_i = 1'b0; ce = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_lock_burst();
    test_timeout();
    test_abort();
    test_rst_ce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
